// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM slave: FSM state encodings, frame command codes and sizes.
// Optional read-address auto-increment is controlled by the SPI_RD_ADDR_AUTOINC_EN macro.
package spi_ram_pkg;

    localparam int unsigned FRAME_W       = 10;
    localparam int unsigned DEF_MEM_DEPTH = 256;
    localparam int unsigned DEF_ADDR_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        CHK_CMD   = 3'b001,
        WRITE     = 3'b010,
        READ_ADD  = 3'b011,
        READ_DATA = 3'b100
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram.sv
// Single-port byte RAM decoding 10-bit command frames into address latches, writes and read fetches.
// SPI_RD_ADDR_AUTOINC_EN: rd_addr advances (wrapping) after every read-data fetch.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [7:0]         dout,
    output logic               tx_valid
);

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           cmd;

    assign cmd = din[FRAME_W-1 -: 2];

    function automatic logic [ADDR_SIZE-1:0] wrap_addr(input logic [7:0] a);
        return ADDR_SIZE'(32'(a) % MEM_DEPTH);
    endfunction

    // Storage is deliberately left out of reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && cmd == CMD_WR_DATA)
            mem[wr_addr] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= wrap_addr(din[7:0]);
                    CMD_RD_ADDR: rd_addr <= wrap_addr(din[7:0]);
                    CMD_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
`ifdef SPI_RD_ADDR_AUTOINC_EN
                        rd_addr  <= (rd_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : rd_addr + 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI slave front end (MSB-first 10-bit frames) driving the spi_ram byte store; read data returned on MISO.
// SPI_RD_ADDR_AUTOINC_EN: keeps rd_flag set after a read so consecutive read-data frames stream bytes.
//
// state     | meaning
// IDLE      | waiting for SS_n low
// CHK_CMD   | sample leading bit: 0 write path, 1 read path (rd_flag picks addr vs data)
// WRITE     | shift a write-address / write-data frame
// READ_ADD  | shift a read-address frame, then set rd_flag
// READ_DATA | shift a read-data frame, then return the fetched byte on MISO
module spi_ram_wrapper
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic MOSI,
    input  logic SS_n,
    input  logic clk,
    input  logic rst_n,
    output logic MISO
);

    state_t             state;
    logic [3:0]         cnt;
    logic [FRAME_W-2:0] shreg;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic               frame_done;
    logic               tx_busy;
    logic               rd_flag;
    logic [7:0]         tx_shift;
    logic [7:0]         dout;
    logic               tx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            tx_busy    <= 1'b0;
            rd_flag    <= 1'b0;
            tx_shift   <= '0;
            MISO       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                state      <= IDLE;
                cnt        <= '0;
                frame_done <= 1'b0;
                tx_busy    <= 1'b0;
                MISO       <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= CHK_CMD;
                    CHK_CMD: begin
                        cnt        <= 4'(FRAME_W - 1);
                        frame_done <= 1'b0;
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_flag)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            shreg <= {shreg[FRAME_W-3:0], MOSI};
                            if (cnt == 4'd0) begin
                                rx_data    <= {shreg, MOSI};
                                rx_valid   <= 1'b1;
                                frame_done <= 1'b1;
                                if (state == READ_ADD)
                                    rd_flag <= 1'b1;
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end else if (state == READ_DATA) begin
                            // cnt is reused to count the 7 bits remaining after dout[7].
                            if (tx_valid && !tx_busy) begin
                                MISO     <= dout[7];
                                tx_shift <= {dout[6:0], 1'b0};
                                cnt      <= 4'd7;
                                tx_busy  <= 1'b1;
                            end else if (tx_busy) begin
                                if (cnt != 4'd0) begin
                                    MISO     <= tx_shift[7];
                                    tx_shift <= {tx_shift[6:0], 1'b0};
                                    cnt      <= cnt - 4'd1;
`ifndef SPI_RD_ADDR_AUTOINC_EN
                                    if (cnt == 4'd1)
                                        rd_flag <= 1'b0;
`endif
                                end else begin
                                    MISO    <= 1'b0;
                                    tx_busy <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) ram_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (rx_data),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Self-checking bench for spi_ram_wrapper: frame driver with a read-byte scoreboard and memory model.
// Honours SPI_RD_ADDR_AUTOINC_EN when deciding how sequential reads are issued and predicted.
module tb_spi_ram_wrapper;
    import spi_ram_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MOSI  = 1'b0;
    logic SS_n  = 1'b1;
    logic MISO;

    int checks  = 0;
    int errors  = 0;
    int rxv_cnt = 0;

    logic [7:0] exp_mem [0:255];
    logic [7:0] m_wr_addr = 8'd0;
    logic [7:0] m_rd_addr = 8'd0;
    logic [7:0] exp_q [$];

    spi_ram_wrapper dut (
        .MOSI  (MOSI),
        .SS_n  (SS_n),
        .clk   (clk),
        .rst_n (rst_n),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && dut.rx_valid) rxv_cnt++;

    // Drives one full frame (leading bit + 10 bits); leaves SS_n high for exactly one edge on return.
    task automatic send_frame(input logic [1:0] cmd, input logic [7:0] payload);
        logic [10:0] bits;
        logic [7:0]  got;
        logic [7:0]  exp;
        bits = {cmd[1], cmd, payload};
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk); MOSI = bits[i];
        end
        case (cmd)
            CMD_WR_ADDR: m_wr_addr = payload;
            CMD_WR_DATA: exp_mem[m_wr_addr] = payload;
            CMD_RD_ADDR: m_rd_addr = payload;
            default: begin
                exp_q.push_back(exp_mem[m_rd_addr]);
`ifdef SPI_RD_ADDR_AUTOINC_EN
                m_rd_addr = m_rd_addr + 8'd1;
`endif
            end
        endcase
        @(negedge clk);
        checks++;
        if (dut.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rx_valid_after_frame cmd=%b got %b want 1", cmd, dut.rx_valid);
        end
        if (cmd == CMD_RD_ADDR) begin
            checks++;
            if (dut.rd_flag !== 1'b1) begin
                errors++;
                $display("FAIL rd_flag_set got %b want 1", dut.rd_flag);
            end
        end
        if (cmd == CMD_RD_DATA) begin
            @(negedge clk);
            checks++;
            if (MISO !== 1'b0) begin
                errors++;
                $display("FAIL miso_before_first_bit got %b want 0", MISO);
            end
            got = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                @(negedge clk); got[b] = MISO;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got %h want queued byte", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL miso_byte got %h want %h", got, exp);
                end
            end
            @(negedge clk);
            checks++;
            if (MISO !== 1'b0) begin
                errors++;
                $display("FAIL miso_after_byte got %b want 0", MISO);
            end
`ifndef SPI_RD_ADDR_AUTOINC_EN
            checks++;
            if (dut.rd_flag !== 1'b0) begin
                errors++;
                $display("FAIL rd_flag_cleared got %b want 0", dut.rd_flag);
            end
`endif
        end
        @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1;
        repeat (5) @(negedge clk);
        checks += 4;
        if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", MISO); end
        if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
        if (dut.rd_flag !== 1'b0) begin errors++; $display("FAIL reset_rd_flag got %b want 0", dut.rd_flag); end
        if (dut.ram_inst.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", dut.ram_inst.tx_valid); end
        rst_n = 1'b1;
        m_wr_addr = 8'd0; m_rd_addr = 8'd0;
    endtask

    task automatic test_write();
        send_frame(CMD_WR_ADDR, 8'h05);
        send_frame(CMD_WR_DATA, 8'h07);
        @(negedge clk);
        checks++;
        if (dut.ram_inst.mem[5] !== 8'h07) begin
            errors++;
            $display("FAIL write_mem5 got %h want 07", dut.ram_inst.mem[5]);
        end
    endtask

    task automatic test_read();
        send_frame(CMD_RD_ADDR, 8'h05);
        send_frame(CMD_RD_DATA, 8'h00);
    endtask

    task automatic test_preload_read();
        send_frame(CMD_WR_ADDR, 8'h03);
        send_frame(CMD_WR_DATA, 8'hA5);
        send_frame(CMD_RD_ADDR, 8'h03);
        send_frame(CMD_RD_DATA, 8'h00);
    endtask

    task automatic test_abort();
        logic [10:0] bits;
        int rx_before;
        send_frame(CMD_WR_ADDR, 8'h05);
        bits = {1'b0, CMD_WR_DATA, 8'hFF};
        rx_before = rxv_cnt;
        @(negedge clk); SS_n = 1'b0;
        for (int i = 10; i >= 5; i--) begin
            @(negedge clk); MOSI = bits[i];
        end
        @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL abort_state got %0d want %0d", dut.state, IDLE); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (rxv_cnt !== rx_before) begin errors++; $display("FAIL abort_rx_valid got %0d want %0d", rxv_cnt, rx_before); end
        if (dut.ram_inst.mem[5] !== exp_mem[5]) begin
            errors++;
            $display("FAIL abort_mem5 got %h want %h", dut.ram_inst.mem[5], exp_mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(CMD_WR_ADDR, 8'h03);
        send_frame(CMD_WR_DATA, 8'h11);
        send_frame(CMD_WR_ADDR, 8'h04);
        send_frame(CMD_WR_DATA, 8'h22);
        send_frame(CMD_RD_ADDR, 8'h03);
        send_frame(CMD_RD_DATA, 8'h00);
`ifndef SPI_RD_ADDR_AUTOINC_EN
        send_frame(CMD_RD_ADDR, 8'h04);
`endif
        send_frame(CMD_RD_DATA, 8'h00);
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        bits = {1'b1, CMD_RD_ADDR, 8'h3C};
        @(negedge clk); SS_n = 1'b0;
        for (int i = 10; i >= 6; i--) begin
            @(negedge clk); MOSI = bits[i];
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 4;
        if (dut.state !== IDLE) begin errors++; $display("FAIL midrst_state got %0d want %0d", dut.state, IDLE); end
        if (dut.cnt !== 4'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", dut.cnt); end
        if (dut.rd_flag !== 1'b0) begin errors++; $display("FAIL midrst_rd_flag got %b want 0", dut.rd_flag); end
        if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b want 0", MISO); end
        SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_wr_addr = 8'd0; m_rd_addr = 8'd0;
        send_frame(CMD_RD_ADDR, 8'h05);
        send_frame(CMD_RD_DATA, 8'h00);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_preload_read();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
